drc_frame_ctrl: RTL and testbench

- Frame-capture sequencer downstream of the DVP pixel FIFO.
- Drives cam_rx_en to enable and disable camera reception.
- Consumes the pixel-info stream of {vsync_flag, hsync_flag, data}, aligns capture to a frame start, and counts columns and rows against the configured geometry.
- Emits a framed pixel stream with SOF/EOL/EOF markers, plus done and error pulses for the DVP register block.

---
 rtl/drc_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_drc_frame_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : drc_frame_ctrl
// Brief    : Frame-capture sequencer behind the DVP pixel FIFO. Aligns capture
//            to a vsync-flagged word, counts columns/rows against a latched
//            geometry and emits a framed pixel stream with SOF/EOL/EOF plus
//            done/error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module drc_frame_ctrl #(
    parameter int DVP_DATA_W = 8,
    parameter int PXL_INFO_W = DVP_DATA_W + 2,
    parameter int COL_W      = 12,
    parameter int ROW_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_continuous,
    input  logic [COL_W-1:0]      cfg_width_m1,
    input  logic [ROW_W-1:0]      cfg_height_m1,
    output logic                  cam_rx_en,
    input  logic [PXL_INFO_W-1:0] pxl_info_dat,
    input  logic                  pxl_info_vld,
    output logic                  pxl_info_rdy,
    output logic [DVP_DATA_W-1:0] pxl_dat,
    output logic                  pxl_sof,
    output logic                  pxl_eol,
    output logic                  pxl_eof,
    output logic                  pxl_vld,
    input  logic                  pxl_rdy,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_line,
    output logic                  err_frame
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_sof = 2'd1;
    localparam logic [1:0] c_st_capture  = 2'd2;

    logic [1:0]       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_width_m1;
    logic [ROW_W-1:0] r_height_m1;
    logic             r_stop_pending;
    logic             r_frame_done;
    logic             r_err_line;
    logic             r_err_frame;

    logic                  w_vs;
    logic                  w_hs;
    logic [DVP_DATA_W-1:0] w_data;
    logic                  w_in_idle;
    logic                  w_in_wait;
    logic                  w_in_cap;
    logic [COL_W-1:0]      w_ec;
    logic [ROW_W-1:0]      w_er;
    logic                  w_line_err;
    logic                  w_frame_err;
    logic                  w_sof;
    logic                  w_eol;
    logic                  w_eof;
    logic                  w_xfer;
    logic                  w_go_again;

    assign w_vs   = pxl_info_dat[PXL_INFO_W-1];
    assign w_hs   = pxl_info_dat[PXL_INFO_W-2];
    assign w_data = pxl_info_dat[DVP_DATA_W-1:0];

    assign w_in_idle = (r_state == c_st_idle);
    assign w_in_wait = (r_state == c_st_wait_sof);
    assign w_in_cap  = (r_state == c_st_capture);

    // Effective position: a misplaced sync flag re-anchors the current byte
    always_comb begin
        w_ec        = r_col;
        w_er        = r_row;
        w_line_err  = 1'b0;
        w_frame_err = 1'b0;
        if (w_vs && ((r_col != '0) || (r_row != '0))) begin
            w_ec        = '0;
            w_er        = '0;
            w_frame_err = 1'b1;
        end else if (w_hs && !w_vs && (r_col != '0)) begin
            w_ec       = '0;
            w_er       = (r_row == r_height_m1) ? '0 : r_row + ROW_W'(1);
            w_line_err = 1'b1;
        end
    end

    assign w_sof  = (w_ec == '0) && (w_er == '0);
    assign w_eol  = (w_ec == r_width_m1);
    assign w_eof  = w_eol && (w_er == r_height_m1);
    assign w_xfer = w_in_cap && pxl_info_vld && pxl_rdy;

    // Back-to-back capture only when nobody asked to stop during this frame
    assign w_go_again = cfg_continuous && !r_stop_pending && !cfg_stop;

    // Input-side ready: drain in IDLE, hold the vsync word in WAIT_SOF, follow downstream in CAPTURE
    always_comb begin
        pxl_info_rdy = 1'b1;
        if (w_in_wait) begin
            pxl_info_rdy = ~w_vs;
        end else if (w_in_cap) begin
            pxl_info_rdy = pxl_rdy;
        end
    end

    assign cam_rx_en  = ~w_in_idle;
    assign busy       = ~w_in_idle;
    assign pxl_vld    = w_in_cap && pxl_info_vld;
    assign pxl_dat    = w_data;
    assign pxl_sof    = w_in_cap && w_sof;
    assign pxl_eol    = w_in_cap && w_eol;
    assign pxl_eof    = w_in_cap && w_eof;
    assign frame_done = r_frame_done;
    assign err_line   = r_err_line;
    assign err_frame  = r_err_frame;

    // Sequencer state, position counters, geometry latch and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_col          <= '0;
            r_row          <= '0;
            r_width_m1     <= '0;
            r_height_m1    <= '0;
            r_stop_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_line     <= 1'b0;
            r_err_frame    <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && w_eof;
            r_err_line   <= w_xfer && w_line_err;
            r_err_frame  <= w_xfer && w_frame_err;

            case (r_state)
                c_st_idle: begin
                    if (cfg_start) begin
                        r_state        <= c_st_wait_sof;
                        r_stop_pending <= cfg_stop;
                        r_width_m1     <= cfg_width_m1;
                        r_height_m1    <= cfg_height_m1;
                    end
                end
                c_st_wait_sof: begin
                    if (cfg_stop) begin
                        r_state <= c_st_idle;
                    end else if (pxl_info_vld && w_vs) begin
                        r_state <= c_st_capture;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                c_st_capture: begin
                    if (cfg_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_eof) begin
                            r_col <= '0;
                            r_row <= '0;
                            if (w_go_again) begin
                                r_state     <= c_st_wait_sof;
                                r_width_m1  <= cfg_width_m1;
                                r_height_m1 <= cfg_height_m1;
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end else if (w_eol) begin
                            r_col <= '0;
                            r_row <= w_er + ROW_W'(1);
                        end else begin
                            r_col <= w_ec + COL_W'(1);
                            r_row <= w_er;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_drc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_drc_frame_ctrl
// Brief    : Table-driven self-checking bench for drc_frame_ctrl, plus a
//            hand-written asynchronous-reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drc_frame_ctrl;

    localparam int DW = 8;
    localparam int IW = DW + 2;
    localparam int CW = 12;
    localparam int RW = 12;

    typedef struct {
        logic          start;
        logic          stop;
        logic          cont;
        logic [CW-1:0] w;
        logic [RW-1:0] h;
        logic          vld;
        logic          vs;
        logic          hs;
        logic [7:0]    d;
        logic          rdy;
        logic          e_irdy;
        logic          e_ovld;
        logic          e_sof;
        logic          e_eol;
        logic          e_eof;
        logic          e_cam;
        logic          e_done;
        logic          e_el;
        logic          e_ef;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_stop;
    logic          cfg_continuous;
    logic [CW-1:0] cfg_width_m1;
    logic [RW-1:0] cfg_height_m1;
    logic          cam_rx_en;
    logic [IW-1:0] pxl_info_dat;
    logic          pxl_info_vld;
    logic          pxl_info_rdy;
    logic [DW-1:0] pxl_dat;
    logic          pxl_sof;
    logic          pxl_eol;
    logic          pxl_eof;
    logic          pxl_vld;
    logic          pxl_rdy;
    logic          busy;
    logic          frame_done;
    logic          err_line;
    logic          err_frame;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t          tbl[$];
    logic [CW-1:0] cg_w    = 12'd3;
    logic [RW-1:0] cg_h    = 12'd1;
    logic          cg_cont = 1'b0;

    drc_frame_ctrl #(
        .DVP_DATA_W(DW),
        .PXL_INFO_W(IW),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_continuous(cfg_continuous),
        .cfg_width_m1  (cfg_width_m1),
        .cfg_height_m1 (cfg_height_m1),
        .cam_rx_en     (cam_rx_en),
        .pxl_info_dat  (pxl_info_dat),
        .pxl_info_vld  (pxl_info_vld),
        .pxl_info_rdy  (pxl_info_rdy),
        .pxl_dat       (pxl_dat),
        .pxl_sof       (pxl_sof),
        .pxl_eol       (pxl_eol),
        .pxl_eof       (pxl_eof),
        .pxl_vld       (pxl_vld),
        .pxl_rdy       (pxl_rdy),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_line      (err_line),
        .err_frame     (err_frame)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic st, input logic sp, input logic vl,
                                input logic vs, input logic hs, input logic [7:0] d,
                                input logic rd, input logic irdy, input logic ovld,
                                input logic sof, input logic eol, input logic eof,
                                input logic cam, input logic dn, input logic el,
                                input logic ef);
        vec_t x;
        x.start = st;   x.stop = sp;    x.cont = cg_cont;
        x.w = cg_w;     x.h = cg_h;
        x.vld = vl;     x.vs = vs;      x.hs = hs;      x.d = d;    x.rdy = rd;
        x.e_irdy = irdy; x.e_ovld = ovld;
        x.e_sof = sof;  x.e_eol = eol;  x.e_eof = eof;  x.e_cam = cam;
        x.e_done = dn;  x.e_el = el;    x.e_ef = ef;
        tbl.push_back(x);
    endfunction

    // IDLE or WAIT_SOF cycle with a non-vsync word (or none): always drained
    function automatic void ctl(input logic st, input logic sp, input logic vl,
                                input logic [7:0] d, input logic cam);
        add(st, sp, vl, 1'b0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cam, 1'b0, 1'b0, 1'b0);
    endfunction

    // WAIT_SOF cycle presenting the vsync word: held, not consumed
    function automatic void sofw(input logic [7:0] d);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    // CAPTURE cycle with downstream ready
    function automatic void px(input logic vs, input logic hs, input logic [7:0] d,
                               input logic sof, input logic eol, input logic eof,
                               input logic dn, input logic el, input logic ef);
        add(1'b0, 1'b0, 1'b1, vs, hs, d, 1'b1, 1'b1, 1'b1, sof, eol, eof, 1'b1, dn, el, ef);
    endfunction

    // CAPTURE cycle with downstream stalled
    function automatic void stl(input logic [7:0] d);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    // Clean 4x2 frame starting at byte value b
    function automatic void frame8(input logic [7:0] b);
        px(1'b1, 1'b0, b,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, b + 8'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    // Entered at posedge+1; each vector occupies one clock
    task automatic run_range(input int lo, input int hi);
        logic [14:0] g, e;
        logic [2:0]  gp, ep;
        for (int i = lo; i <= hi; i++) begin
            cfg_start      = tbl[i].start;
            cfg_stop       = tbl[i].stop;
            cfg_continuous = tbl[i].cont;
            cfg_width_m1   = tbl[i].w;
            cfg_height_m1  = tbl[i].h;
            pxl_info_vld   = tbl[i].vld;
            pxl_info_dat   = {tbl[i].vs, tbl[i].hs, tbl[i].d};
            pxl_rdy        = tbl[i].rdy;
            #2;
            g = {pxl_info_rdy, pxl_vld, cam_rx_en, busy,
                 (tbl[i].e_ovld ? {pxl_sof, pxl_eol, pxl_eof, pxl_dat} : 11'd0)};
            e = {tbl[i].e_irdy, tbl[i].e_ovld, tbl[i].e_cam, tbl[i].e_cam,
                 (tbl[i].e_ovld ? {tbl[i].e_sof, tbl[i].e_eol, tbl[i].e_eof, tbl[i].d} : 11'd0)};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL comb[%0d] {irdy,vld,cam,busy,sof,eol,eof,dat}: got %b expected %b", i, g, e);
            end
            @(posedge clk);
            #1;
            gp = {frame_done, err_line, err_frame};
            ep = {tbl[i].e_done, tbl[i].e_el, tbl[i].e_ef};
            n_cmp++;
            if (gp !== ep) begin
                n_fail++;
                $display("FAIL pulse[%0d] {done,err_line,err_frame}: got %b expected %b", i, gp, ep);
            end
        end
        cfg_start    = 1'b0;
        cfg_stop     = 1'b0;
        pxl_info_vld = 1'b0;
        pxl_rdy      = 1'b1;
    endtask

    task automatic check_idle_outputs(input string name);
        logic [6:0] g;
        g = {busy, cam_rx_en, pxl_vld, pxl_info_rdy, frame_done, err_line, err_frame};
        n_cmp++;
        if (g !== 7'b0001000) begin
            n_fail++;
            $display("FAIL %s {busy,cam,vld,irdy,done,el,ef}: got %b expected 0001000", name, g);
        end
    endtask

    initial begin
        int n_main;
        int h2_lo;

        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_stop       = 1'b0;
        cfg_continuous = 1'b0;
        cfg_width_m1   = 12'd3;
        cfg_height_m1  = 12'd1;
        pxl_info_dat   = '0;
        pxl_info_vld   = 1'b1;
        pxl_rdy        = 1'b1;

        // A: single 4x2 frame, two garbage words dropped in WAIT_SOF
        cg_cont = 1'b0;
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        ctl(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1);
        sofw(8'h10);
        frame8(8'h10);
        ctl(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);

        // B: continuous, second frame stopped mid-way still completes
        cg_cont = 1'b1;
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'h20);
        frame8(8'h20);
        ctl(1'b0, 1'b0, 1'b1, 8'hCC, 1'b1);
        sofw(8'h30);
        px(1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h37, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // C: hsync on byte 2 of line 0 re-anchors to row 1 col 0
        cg_cont = 1'b0;
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'h40);
        px(1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        px(1'b0, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h45, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);

        // D: vsync on byte 5 restarts the frame
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'h50);
        px(1'b1, 1'b0, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h54, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h57, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h58, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h5C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // E: start+stop together in continuous mode gives exactly one frame
        cg_cont = 1'b1;
        ctl(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        sofw(8'h60);
        frame8(8'h60);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // F: stop while waiting for SOF returns to IDLE
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ctl(1'b0, 1'b1, 1'b1, 8'hDD, 1'b1);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // G: width_m1=0 latched; later config change is ignored
        cg_cont = 1'b0;
        cg_w    = 12'd0;
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cg_w    = 12'd3;
        sofw(8'h70);
        px(1'b1, 1'b0, 8'h70, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h71, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // S: downstream stall of 5 cycles mid-line
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'h80);
        px(1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) stl(8'h82);
        px(1'b0, 1'b0, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h83, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h85, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h86, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h87, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // H1: partial frame that the reset will abandon
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'h90);
        px(1'b1, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 8'h91, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_main = tbl.size();

        // H2: clean recapture after reset
        h2_lo = tbl.size();
        ctl(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sofw(8'hA0);
        frame8(8'hA0);
        ctl(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        #12;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_range(0, n_main - 1);

        // Asynchronous reset in the middle of CAPTURE with a word pending
        pxl_info_vld = 1'b1;
        pxl_info_dat = {2'b00, 8'h92};
        #2;
        n_cmp++;
        if (pxl_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_vld: got %b expected 1", pxl_vld);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        pxl_info_vld = 1'b0;
        check_idle_outputs("after_reset");

        run_range(h2_lo, tbl.size() - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
